pwm_scheduler: RTL and testbench

- Multi-channel PWM controller built around one shared period up-counter.
- Sequences the counter through start, run and drain, and owns the period and per-channel duty configuration.
- Configuration writes go to shadow registers and load only at period boundaries, so output waveforms never glitch.
- Sits between the register/config interface and the PWM output pins.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_scheduler_if.sv | 45 ++++
 rtl/pwm_period_counter.sv | 40 ++++
 rtl/pwm_scheduler.sv | 126 ++++++++++++
 tb/tb_pwm_scheduler.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
//  Module   : pwm_pkg
//  Brief    : Scheduler state encoding and reset constants for pwm_scheduler.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10,
      ST_BAD   = 2'b11
   } state_t;

   // Wide constants; users slice them down to their own BITS.
   localparam logic [31:0] C_PERIOD_RST = 32'hFFFF_FFFF;
   localparam logic [32:0] C_DUTY_RST   = 33'd0;

endpackage

`default_nettype wire

// File: rtl/pwm_scheduler_if.sv
// ============================================================================
//  Module   : pwm_scheduler_if
//  Brief    : Control/config and PWM output bundle; PWM_POLARITY_EN adds polarity.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface pwm_scheduler_if #(
   parameter int BITS = 8,
   parameter int CH   = 4,
   parameter int SELW = 2
);
   logic            start;
   logic            stop;
   logic            period_we;
   logic [BITS-1:0] period_in;
   logic            duty_we;
   logic [SELW-1:0] duty_sel;
   logic [BITS:0]   duty_in;
`ifdef PWM_POLARITY_EN
   logic            pol_we;
   logic [CH-1:0]   pol_in;
`endif
   logic [CH-1:0]   pwm_out;
   logic            busy;
   logic            period_end;
   logic [BITS-1:0] cnt;

`ifdef PWM_POLARITY_EN
   modport master (output start, stop, period_we, period_in, duty_we, duty_sel, duty_in,
                   pol_we, pol_in,
                   input  pwm_out, busy, period_end, cnt);
   modport slave  (input  start, stop, period_we, period_in, duty_we, duty_sel, duty_in,
                   pol_we, pol_in,
                   output pwm_out, busy, period_end, cnt);
`else
   modport master (output start, stop, period_we, period_in, duty_we, duty_sel, duty_in,
                   input  pwm_out, busy, period_end, cnt);
   modport slave  (input  start, stop, period_we, period_in, duty_we, duty_sel, duty_in,
                   output pwm_out, busy, period_end, cnt);
`endif

endinterface

`default_nettype wire

// File: rtl/pwm_period_counter.sv
// ============================================================================
//  Module   : pwm_period_counter
//  Brief    : Period up-counter that wraps to 0 after reaching the terminal count.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_period_counter #(
   parameter int BITS = 8
) (
   input  wire logic            clk,
   input  wire logic            rstn,
   input  wire logic            en,
   input  wire logic            clr,
   input  wire logic [BITS-1:0] period,
   output logic      [BITS-1:0] cnt,
   output logic                 wrap
);

   logic [BITS-1:0] r_cnt;
   logic            w_term;

   assign w_term = (r_cnt == period);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_term ? '0 : r_cnt + 1'b1;
      end
   end

   assign cnt  = r_cnt;
   assign wrap = en && w_term;

endmodule

`default_nettype wire

// File: rtl/pwm_scheduler.sv
// ============================================================================
//  Module   : pwm_scheduler
//  Brief    : Multi-channel PWM on a shared counter with boundary-loaded shadow
//             config; PWM_POLARITY_EN adds per-channel output inversion.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_scheduler #(
   parameter int BITS = 8,
   parameter int CH   = 4,
   parameter int SELW = 2
) (
   input  wire logic      clk,
   input  wire logic      rstn,
   pwm_scheduler_if.slave bus
);
   import pwm_pkg::*;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_busy;
   logic            w_clr;
   logic            w_load;
   logic            w_period_end;
   logic [BITS-1:0] w_cnt;
   logic [BITS-1:0] r_period_pend;
   logic [BITS-1:0] r_period_act;
   logic [CH-1:0]   w_pwm;

   assign w_busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_clr  = !w_busy;
   // Active config follows pending continuously while idle, else only at the boundary.
   assign w_load = (r_state == ST_IDLE) || w_period_end;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = ST_IDLE;
      case (r_state)
         ST_IDLE:  w_state_nxt = (bus.start && !bus.stop) ? ST_RUN : ST_IDLE;
         ST_RUN:   w_state_nxt = bus.stop ? ST_DRAIN : ST_RUN;
         ST_DRAIN: begin
            if (bus.start && !bus.stop) w_state_nxt = ST_RUN;
            else if (w_period_end)      w_state_nxt = ST_IDLE;
            else                        w_state_nxt = ST_DRAIN;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   pwm_period_counter #(
      .BITS (BITS)
   ) u_counter (
      .clk    (clk),
      .rstn   (rstn),
      .en     (w_busy),
      .clr    (w_clr),
      .period (r_period_act),
      .cnt    (w_cnt),
      .wrap   (w_period_end)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_period_pend <= C_PERIOD_RST[BITS-1:0];
         r_period_act  <= C_PERIOD_RST[BITS-1:0];
      end else begin
         if (bus.period_we) r_period_pend <= bus.period_in;
         if (w_load)        r_period_act  <= r_period_pend;
      end
   end

   generate
      for (genvar i = 0; i < CH; i++) begin : g_ch
         logic [BITS:0] r_duty_pend;
         logic [BITS:0] r_duty_act;
         logic          w_sel_hit;
         logic          w_on;

         // Selects at or above CH match no channel, so those writes drop.
         assign w_sel_hit = bus.duty_we && (bus.duty_sel == SELW'(i));
         assign w_on      = w_busy && ({1'b0, w_cnt} < r_duty_act);

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_duty_pend <= C_DUTY_RST[BITS:0];
               r_duty_act  <= C_DUTY_RST[BITS:0];
            end else begin
               if (w_sel_hit) r_duty_pend <= bus.duty_in;
               if (w_load)    r_duty_act  <= r_duty_pend;
            end
         end

`ifdef PWM_POLARITY_EN
         logic r_pol_pend;
         logic r_pol_act;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_pol_pend <= 1'b0;
               r_pol_act  <= 1'b0;
            end else begin
               if (bus.pol_we) r_pol_pend <= bus.pol_in[i];
               if (w_load)     r_pol_act  <= r_pol_pend;
            end
         end

         assign w_pwm[i] = r_pol_act ^ w_on;
`else
         assign w_pwm[i] = w_on;
`endif
      end
   endgenerate

   assign bus.pwm_out    = w_pwm;
   assign bus.busy       = w_busy;
   assign bus.period_end = w_period_end;
   assign bus.cnt        = w_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pwm_scheduler.sv
// ============================================================================
//  Module   : tb_pwm_scheduler
//  Brief    : Self-checking bench for pwm_scheduler (honours PWM_POLARITY_EN).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_scheduler;

   localparam int BITS = 8;
   localparam int CH   = 4;
   localparam int SELW = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   pwm_scheduler_if #(.BITS(BITS), .CH(CH), .SELW(SELW)) bus ();

   pwm_scheduler #(.BITS(BITS), .CH(CH), .SELW(SELW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: mode, phase and config snapshots ----------
   int        m_mode;                 // 0 idle, 1 run, 2 drain
   int        m_cnt;
   int        m_per_p, m_per_a;
   int        m_duty_p [CH];
   int        m_duty_a [CH];
   bit [CH-1:0] m_pol_p, m_pol_a;

   function automatic bit m_busy();
      return m_mode != 0;
   endfunction

   function automatic bit m_pe();
      return (m_mode != 0) && (m_cnt == m_per_a);
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_mode  <= 0;
         m_cnt   <= 0;
         m_per_p <= 255;
         m_per_a <= 255;
         m_pol_p <= '0;
         m_pol_a <= '0;
         foreach (m_duty_p[k]) begin
            m_duty_p[k] <= 0;
            m_duty_a[k] <= 0;
         end
      end else begin
         if (!m_busy() || m_pe()) begin
            m_per_a <= m_per_p;
            m_pol_a <= m_pol_p;
            foreach (m_duty_a[k]) m_duty_a[k] <= m_duty_p[k];
         end
         if (bus.period_we) m_per_p <= int'(bus.period_in);
         if (bus.duty_we && int'(bus.duty_sel) < CH) m_duty_p[bus.duty_sel] <= int'(bus.duty_in);
`ifdef PWM_POLARITY_EN
         if (bus.pol_we) m_pol_p <= bus.pol_in;
`endif
         case (m_mode)
            0:       if (bus.start && !bus.stop) m_mode <= 1;
            1:       if (bus.stop) m_mode <= 2;
            default: if (bus.start && !bus.stop) m_mode <= 1;
                     else if (m_pe()) m_mode <= 0;
         endcase
         m_cnt <= (m_busy() && !m_pe()) ? m_cnt + 1 : 0;
      end
   end

   function automatic logic [31:0] model_vec();
      logic [CH-1:0] pwm;
      for (int k = 0; k < CH; k++)
         pwm[k] = m_pol_a[k] ^ (m_busy() && (m_cnt < m_duty_a[k]));
      return {18'd0, pwm, m_busy(), m_pe(), 8'(m_cnt)};
   endfunction

   always @(negedge clk) begin
      if (chk_en && rstn)
         check("cycle", {18'd0, bus.pwm_out, bus.busy, bus.period_end, bus.cnt}, model_vec());
   end

   // ---------------- stimulus helpers (all start and end on a falling edge) -----
   task automatic wr_period(input int v);
      bus.period_in = BITS'(v);
      bus.period_we = 1'b1;
      @(negedge clk);
      bus.period_we = 1'b0;
   endtask

   task automatic wr_duty(input int sel, input int v);
      bus.duty_sel = SELW'(sel);
      bus.duty_in  = (BITS+1)'(v);
      bus.duty_we  = 1'b1;
      @(negedge clk);
      bus.duty_we  = 1'b0;
   endtask

   task automatic pulse(input bit s, input bit p);
      bus.start = s;
      bus.stop  = p;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
   endtask

   task automatic wait_pe();
      int k = 0;
      while (bus.period_end !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("pe_timeout", {31'd0, bus.period_end}, 32'd1);
   endtask

   task automatic count_highs(input int ch, input int n, output int h);
      h = 0;
      repeat (n) begin
         h += int'(bus.pwm_out[ch]);
         @(negedge clk);
      end
   endtask

   initial begin
      int h;
      int pe_at;
      bus.start = 0; bus.stop = 0; bus.period_we = 0; bus.period_in = '0;
      bus.duty_we = 0; bus.duty_sel = '0; bus.duty_in = '0;
`ifdef PWM_POLARITY_EN
      bus.pol_we = 0; bus.pol_in = '0;
`endif
      repeat (3) @(negedge clk);
      rstn   = 1'b1;
      chk_en = 1'b1;
      check("rst_cnt",  32'(bus.cnt), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_pwm",  32'(bus.pwm_out), 32'd0);
      check("rst_pe",   32'(bus.period_end), 32'd0);

      // Basic 3/10 waveform, first boundary ten cycles after start.
      wr_period(9);
      wr_duty(0, 3);
      @(negedge clk);
      bus.start = 1'b1;
      pe_at = 0; h = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         h += int'(bus.pwm_out[0]);
         if (bus.period_end && pe_at == 0) pe_at = k;
      end
      check("first_pe_cycle", 32'(pe_at), 32'd10);
      check("duty3_period1", 32'(h), 32'd3);
      @(negedge clk);
      count_highs(0, 10, h);
      check("duty3_period2", 32'(h), 32'd3);

      // Mid-period write holds until boundary; a boundary-cycle write waits one more.
      repeat (3) @(negedge clk);
      wr_duty(1, 5);
      count_highs(1, 6, h);
      check("duty1_old_hold", 32'(h), 32'd0);
      count_highs(1, 10, h);
      check("duty1_new5", 32'(h), 32'd5);
      wait_pe();
      wr_duty(1, 2);
      count_highs(1, 10, h);
      check("pe_write_deferred", 32'(h), 32'd5);
      count_highs(1, 10, h);
      check("pe_write_applied", 32'(h), 32'd2);

      // Stop at cnt=4 drains to the end of the period.
      repeat (4) @(negedge clk);
      pulse(1'b0, 1'b1);
      wait_pe();
      check("drain_busy", 32'(bus.busy), 32'd1);
      check("drain_last_cnt", 32'(bus.cnt), 32'd9);
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_cnt",  32'(bus.cnt), 32'd0);
      check("idle_pwm",  32'(bus.pwm_out), 32'd0);

      // Start during drain resumes with no gap.
      pulse(1'b1, 1'b0);
      repeat (4) @(negedge clk);
      pulse(1'b0, 1'b1);
      repeat (2) @(negedge clk);
      pulse(1'b1, 1'b0);
      wait_pe();
      @(negedge clk);
      check("resume_busy", 32'(bus.busy), 32'd1);
      check("resume_cnt",  32'(bus.cnt), 32'd0);

      // Simultaneous start+stop: drain from RUN, nothing from IDLE.
      pulse(1'b1, 1'b1);
      wait_pe();
      @(negedge clk);
      check("both_run_idle", 32'(bus.busy), 32'd0);
      pulse(1'b1, 1'b1);
      check("both_idle_stay", 32'(bus.busy), 32'd0);

      // Duty extremes with period=255, then period=0.
      wr_period(255);
      wr_duty(0, 0);
      wr_duty(1, 256);
      pulse(1'b1, 1'b0);
      count_highs(0, 256, h);
      check("duty0_const0", 32'(h), 32'd0);
      count_highs(1, 256, h);
      check("duty256_const1", 32'(h), 32'd256);
      pulse(1'b0, 1'b1);
      wait_pe();
      @(negedge clk);
      wr_period(0);
      @(negedge clk);
      pulse(1'b1, 1'b0);
      h = 0;
      repeat (5) begin
         h += int'(bus.period_end);
         @(negedge clk);
      end
      check("period0_pe_every", 32'(h), 32'd5);
      pulse(1'b0, 1'b1);
      @(negedge clk);
      check("period0_stopped", 32'(bus.busy), 32'd0);

      // Asynchronous reset mid-period discards pending writes.
      wr_period(9);
      @(negedge clk);
      pulse(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      wr_duty(0, 7);
      #2 rstn = 1'b0;
      #1;
      check("arst_outputs", {18'd0, bus.pwm_out, bus.busy, bus.period_end, bus.cnt}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      pulse(1'b1, 1'b0);
      count_highs(0, 12, h);
      check("arst_duty_lost", 32'(h), 32'd0);
      check("arst_period_lost", 32'(bus.cnt), 32'd12);

`ifdef PWM_POLARITY_EN
      pulse(1'b0, 1'b1);
      wait_pe();
      @(negedge clk);
      wr_period(9);
      wr_duty(2, 3);
      bus.pol_in = 4'b0100;
      bus.pol_we = 1'b1;
      @(negedge clk);
      bus.pol_we = 1'b0;
      @(negedge clk);
      check("pol_idle_high", 32'(bus.pwm_out[2]), 32'd1);
      pulse(1'b1, 1'b0);
      count_highs(2, 10, h);
      check("pol_inverted_7", 32'(h), 32'd7);
`endif

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
